// File: rtl/mux_pkg.sv
// Shared definitions for the 16-to-1 lane selector: lane count, select width
// and the single-bit selection helper applied per bit-plane.
package mux_pkg;

    localparam int unsigned N_IN  = 16;
    localparam int unsigned SEL_W = 4;

    // Picks one bit out of a 16-bit plane; wider lanes apply this per bit.
    function automatic logic lane_select(input logic [N_IN-1:0]  bus,
                                         input logic [SEL_W-1:0] idx);
        return bus[idx];
    endfunction

endpackage

// File: rtl/mux_lane_sel.sv
// Purely combinational 16:1 slice selector. Lane k sits at
// in[k*LANE_W +: LANE_W], lane 0 at the LSBs. Shared by the registered and
// the combinational-bypass output paths.
module mux_lane_sel
    import mux_pkg::*;
#(
    parameter int unsigned LANE_W = 1
) (
    input  logic [N_IN*LANE_W-1:0] in,
    input  logic [SEL_W-1:0]       sel,
    output logic [LANE_W-1:0]      out
);

    // Each output bit is a 16:1 pick from the plane made of that bit of every lane.
    for (genvar b = 0; b < LANE_W; b++) begin : g_bit
        logic [N_IN-1:0] plane;
        for (genvar k = 0; k < N_IN; k++) begin : g_lane
            assign plane[k] = in[k*LANE_W + b];
        end
        assign out[b] = lane_select(plane, sel);
    end

endmodule

// File: rtl/mux_16to1.sv
// Registered 16-to-1 selector with capture enable and sticky valid flag.
// Build option MUX_COMB_BYPASS_EN: output becomes combinational
// (0-cycle latency), out_valid follows rst_n and en is ignored.
module mux_16to1
    import mux_pkg::*;
#(
    parameter int unsigned LANE_W = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_IN*LANE_W-1:0] in,
    input  logic [SEL_W-1:0]       sel,
    input  logic                   en,
    output logic [LANE_W-1:0]      out,
    output logic                   out_valid
);

    logic [LANE_W-1:0] sel_data;

    mux_lane_sel #(
        .LANE_W (LANE_W)
    ) u_lane_sel (
        .in  (in),
        .sel (sel),
        .out (sel_data)
    );

`ifdef MUX_COMB_BYPASS_EN

    assign out       = sel_data;
    assign out_valid = rst_n;

`else

    // Capture the selected lane on enabled edges; valid stays set until reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out       <= '0;
            out_valid <= 1'b0;
        end else if (en) begin
            out       <= sel_data;
            out_valid <= 1'b1;
        end
    end

    // An unknown select on a capturing edge would load garbage silently.
    always_ff @(posedge clk) begin
        if (rst_n && en) begin
            assert (!$isunknown(sel));
        end
    end

`endif

endmodule

// File: tb/tb_mux_16to1.sv
module tb_mux_16to1;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         en;
    logic [3:0]   sel;
    logic [15:0]  in1;
    logic [127:0] in8;
    logic         out1;
    logic [7:0]   out8;
    logic         valid1;
    logic         valid8;

    int checks   = 0;
    int failures = 0;

    // Reference state: what the output registers should hold.
    logic       m_out1;
    logic [7:0] m_out8;
    logic       m_valid;

    always #5 clk = ~clk;

    mux_16to1 #(.LANE_W(1)) u_dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in        (in1),
        .sel       (sel),
        .en        (en),
        .out       (out1),
        .out_valid (valid1)
    );

    mux_16to1 #(.LANE_W(8)) u_dut8 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in        (in8),
        .sel       (sel),
        .en        (en),
        .out       (out8),
        .out_valid (valid8)
    );

    function automatic logic pick1(input logic [15:0] bus, input logic [3:0] idx);
        logic [15:0] t;
        t = bus >> idx;
        return t[0];
    endfunction

    function automatic logic [7:0] pick8(input logic [127:0] bus, input logic [3:0] idx);
        logic [127:0] t;
        t = bus >> (32'(idx) * 8);
        return t[7:0];
    endfunction

    function automatic logic exp_out1();
`ifdef MUX_COMB_BYPASS_EN
        return pick1(in1, sel);
`else
        return m_out1;
`endif
    endfunction

    function automatic logic [7:0] exp_out8();
`ifdef MUX_COMB_BYPASS_EN
        return pick8(in8, sel);
`else
        return m_out8;
`endif
    endfunction

    function automatic logic exp_valid();
`ifdef MUX_COMB_BYPASS_EN
        return rst_n;
`else
        return m_valid;
`endif
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".out1"},   32'(out1),   32'(exp_out1()));
        check({tag, ".out8"},   32'(out8),   32'(exp_out8()));
        check({tag, ".valid1"}, 32'(valid1), 32'(exp_valid()));
        check({tag, ".valid8"}, 32'(valid8), 32'(exp_valid()));
    endtask

    // One clock edge: update the reference from the inputs seen at the edge,
    // then sample the DUT 1 time unit later.
    task automatic tick();
        @(posedge clk);
        if (!rst_n) begin
            m_out1  = 1'b0;
            m_out8  = 8'h00;
            m_valid = 1'b0;
        end else if (en) begin
            m_out1  = pick1(in1, sel);
            m_out8  = pick8(in8, sel);
            m_valid = 1'b1;
        end
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "simulation time limit exceeded");
    end

    initial begin
        logic [3:0] dir_sel [6];
        logic       dir_exp [6];
        dir_sel = '{4'd3, 4'd0, 4'd5, 4'd12, 4'd2, 4'd15};
        dir_exp = '{1'b1, 1'b1, 1'b1, 1'b1,  1'b0, 1'b0};

        m_out1 = 1'b0; m_out8 = 8'h00; m_valid = 1'b0;
        rst_n = 1'b1; en = 1'b0; sel = 4'd0; in1 = '0; in8 = '0;
        #2 rst_n = 1'b0;
        #1 check_all("reset");

        // Release reset; en low keeps valid clear.
        tick();
        rst_n = 1'b1;
        tick();
        check_all("post_release_idle");

        // Directed LANE_W=1 picks from 0x30AB.
        for (int i = 0; i < 6; i++) begin
            in1 = 16'h30AB; sel = dir_sel[i]; en = 1'b1;
`ifdef MUX_COMB_BYPASS_EN
            #1 check("bypass_same_delta", 32'(out1), 32'(dir_exp[i]));
`endif
            tick();
            check($sformatf("dir_sel%0d", dir_sel[i]), 32'(out1), 32'(dir_exp[i]));
            check_all($sformatf("dir_sel%0d", dir_sel[i]));
        end

        // Sweep 0x8001: only sel 0 and 15 give 1, one cycle after sel applied.
        in1 = 16'h8001;
        for (int s = 0; s < 16; s++) begin
            sel = 4'(s);
            tick();
            check($sformatf("sweep%0d", s), 32'(out1), 32'((s == 0 || s == 15) ? 1 : 0));
        end

        // Hold: capture sel=3, then changes with en low must not reach out.
        in1 = 16'h30AB; sel = 4'd3; en = 1'b1;
        tick();
        en = 1'b0; in1 = 16'h0000; sel = 4'd7;
        tick();
        tick();
`ifndef MUX_COMB_BYPASS_EN
        check("hold_out", 32'(out1), 32'd1);
`endif
        check_all("hold");
        en = 1'b1;
        tick();
        check("hold_release", 32'(out1), 32'd0);

        // Wide lanes: lane k = 0x10 + k.
        for (int k = 0; k < 16; k++) in8[k*8 +: 8] = 8'(8'h10 + k);
        sel = 4'd9;  tick(); check("wide_sel9",  32'(out8), 32'h19);
        sel = 4'd0;  tick(); check("wide_sel0",  32'(out8), 32'h10);
        sel = 4'd15; tick(); check("wide_sel15", 32'(out8), 32'h1F);

        // Randomized traffic against the reference.
        for (int i = 0; i < 200; i++) begin
            in1 = 16'($urandom);
            in8 = {$urandom, $urandom, $urandom, $urandom};
            sel = 4'($urandom_range(0, 15));
            en  = ($urandom_range(0, 3) != 0);
            tick();
            check_all("random");
        end

        // Asynchronous reset mid-run with out = 1.
        in1 = 16'h0001; sel = 4'd0; en = 1'b1;
        tick();
        check("pre_reset_out", 32'(out1), 32'd1);
        #2 rst_n = 1'b0;
        m_out1 = 1'b0; m_out8 = 8'h00; m_valid = 1'b0;
        #1;
        check("async_rst_out",   32'(out1),   32'd0);
        check("async_rst_valid", 32'(valid1), 32'd0);
        check_all("async_rst");
        tick();
        check_all("rst_held_edge");
        rst_n = 1'b1; en = 1'b0;
        tick();
        check_all("rst_release_idle");
        en = 1'b1;
        tick();
        check("first_capture_valid", 32'(valid1), 32'd1);
        check_all("first_capture");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
